uart_tx: RTL and testbench

- Serial transmitter for the 8N1 link decoded by the team's UART receiver.
- Accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte on `tx`.
- Frame: start bit (0), 8 data bits LSB first, stop bit (1).
- Default bit time is one clock, which matches the receiver's one-sample-per-clock framing. Frames may be sent back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small byte FIFO in front.
// Handshake: a byte is accepted on a rising edge where data_valid && ready;
// ready is combinational and drops only when the FIFO is full, and bytes
// offered while ready is low are dropped rather than held.
// Frames are start(0), eight data bits LSB first, stop(1); each bit lasts
// CLKS_PER_BIT clocks, and consecutive frames follow with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic            tx_n;
    logic [7:0]      shift, shift_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [BW-1:0]   baud_cnt, baud_cnt_n;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic            fifo_empty;
    logic            baud_done;

    assign ready      = (fifo_level != LW'(FIFO_DEPTH));
    assign push       = data_valid && ready;
    assign fifo_empty = (fifo_level == '0);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign baud_done  = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    // FIFO storage: write the accepted byte at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and level; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Serialiser state register; reset drives the line idle high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            baud_cnt <= baud_cnt_n;
        end
    end

    // Next-state, next-bit and FIFO pop decision for the serialiser.
    always_comb begin
        state_n    = state;
        tx_n       = tx;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        baud_cnt_n = baud_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_n    = mem[rd_ptr];
                    tx_n       = 1'b0;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    tx_n       = shift[0];
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. One instance runs at one clock
// per bit with a serial-line decoder feeding a byte scoreboard; a second
// instance runs at four clocks per bit and is checked bit by bit.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in, data_in4;
    logic       data_valid, data_valid4;
    logic       ready, tx, busy;
    logic       ready4, tx4, busy4;
    logic [2:0] level, level4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         frames = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    logic [7:0] exp_b;

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .ready(ready), .tx(tx), .busy(busy), .fifo_level(level)
    );

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in4), .data_valid(data_valid4),
        .ready(ready4), .tx(tx4), .busy(busy4), .fifo_level(level4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // serial decoder for the one-clock-per-bit line, feeding the scoreboard
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (tx === 1'b0) begin
                rx_cnt = 1;
                starts.push_back(cyc);
            end
        end else if (rx_cnt <= 8) begin
            rx_byte = {tx, rx_byte[7:1]};
            rx_cnt++;
        end else begin
            check("rx_stop_bit", tx, 1);
            check("rx_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check("rx_byte", rx_byte, exp_b);
            end
            frames++;
            rx_cnt = 0;
        end
    end

    // driver: offer a byte, hold it until ready, record it as expected
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_timeout", ready, 1);
        exp_q.push_back(b);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames, target);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat_a5;
        logic [9:0] pat_3c;
        logic [7:0] burst [5];
        logic       saw_low;
        int         f0;

        pat_a5 = 10'b1101001010;
        pat_3c = 10'b1001111000;
        burst  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

        // reset
        rst_n = 1'b0;
        data_in = '0; data_valid = 1'b0;
        data_in4 = '0; data_valid4 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_tx4", tx4, 1);
        check("rst_ready4", ready4, 1);
        check("rst_busy4", busy4, 0);
        check("rst_level4", level4, 0);

        // single byte 0xA5 at one clock per bit
        @(negedge clk);
        push_byte(8'hA5);
        check("a5_latency_tx", tx, 1);
        check("a5_latency_level", level, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a5_bit", tx, pat_a5[i]);
            if (i == 0) check("a5_popped_level", level, 0);
            if (i == 9) check("a5_busy_in_stop", busy, 1);
        end
        @(negedge clk);
        check("a5_idle_tx", tx, 1);
        check("a5_busy_done", busy, 0);
        check("a5_frames", frames, 1);

        // back-to-back burst filling the FIFO, then a dropped 0xFF
        starts.delete();
        f0 = frames;
        for (int i = 0; i < 5; i++) push_byte(burst[i]);
        check("burst_full_level", level, 4);
        check("burst_full_ready", ready, 0);
        data_in    = 8'hFF;
        data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drop_level", level, 4);
            check("drop_ready", ready, 0);
        end
        data_valid = 1'b0;
        wait_frames(f0 + 5, 200);
        check("burst_starts", starts.size(), 5);
        if (starts.size() == 5) check("burst_span", starts[4] - starts[0], 40);
        @(negedge clk);
        check("burst_busy_done", busy, 0);
        check("burst_ready_back", ready, 1);
        check("burst_level_empty", level, 0);

        // random bytes, more than the FIFO holds, so the driver stalls on ready
        f0 = frames;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
        wait_frames(f0 + 6, 200);

        // four clocks per bit on the second instance
        @(negedge clk);
        data_in4    = 8'h3C;
        data_valid4 = 1'b1;
        @(negedge clk);
        data_valid4 = 1'b0;
        check("c4_latency_tx", tx4, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("c4_bit", tx4, pat_3c[i / 4]);
        end
        @(negedge clk);
        check("c4_idle_tx", tx4, 1);
        check("c4_busy_done", busy4, 0);

        // reset during data bit 3 of 0x00 with two bytes queued
        f0 = frames;
        push_byte(8'h00);
        push_byte(8'h11);
        push_byte(8'h22);
        check("mid_queued_level", level, 2);
        repeat (3) @(negedge clk);
        check("mid_bit3_low", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_level", level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_low = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("mid_no_frame_after", saw_low, 0);
        check("mid_frames_unchanged", frames, f0);
        check("mid_level_after", level, 0);
        push_byte(8'h5A);
        wait_frames(f0 + 1, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
